chaotic_bit_extractor: RTL



---
 rtl/chaotic_bit_extractor.sv | 96 +++++++++
 1 files changed

// File: rtl/chaotic_bit_extractor.sv
// chaotic_bit_extractor: folds low mantissa bits of valid double triples into words, buffers them, streams MSB-first
// Ports: clk, rst_n (async active-low); n1_valid/xn1/yn1/zn1 sample input;
//        bit_out/bit_valid/bit_ready serial stream; fifo_level, overflow, reject_cnt, drop_cnt debug status.
module chaotic_bit_extractor #(
  parameter int DATA_WIDTH   = 64,
  parameter int EXTRACT_BITS = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            n1_valid,
  input  logic [DATA_WIDTH-1:0]           xn1,
  input  logic [DATA_WIDTH-1:0]           yn1,
  input  logic [DATA_WIDTH-1:0]           zn1,
  output logic                            bit_out,
  output logic                            bit_valid,
  input  logic                            bit_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic [15:0]                     reject_cnt,
  output logic [15:0]                     drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(EXTRACT_BITS + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic s1_valid;
  logic [DATA_WIDTH-1:0] s1_x, s1_y, s1_z;
  logic [EXTRACT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] bit_cnt;
  logic [EXTRACT_BITS-1:0] shreg, word;
  logic bad, wr_req, rej, accept, last, pop, wr, drop;
  // zero/subnormal (exp all 0) and Inf/NaN (exp all 1) carry no usable mantissa entropy
  function automatic logic bad_exp(input logic [DATA_WIDTH-1:0] d);
    return (d[DATA_WIDTH-2 -: 11] == 11'h000) || (d[DATA_WIDTH-2 -: 11] == 11'h7FF);
  endfunction
  always_comb begin
    bad    = bad_exp(s1_x) || bad_exp(s1_y) || bad_exp(s1_z);
    rej    = s1_valid && bad;
    wr_req = s1_valid && !bad;
    word   = s1_x[EXTRACT_BITS-1:0] ^ s1_y[EXTRACT_BITS-1:0] ^ s1_z[EXTRACT_BITS-1:0];
    accept = bit_valid && bit_ready;
    last   = accept && (bit_cnt == CW'(EXTRACT_BITS - 1));
    pop    = (fifo_level != '0) && (state == IDLE || last);
    // a pop in the same cycle frees a slot, so a full FIFO can still take the word
    wr     = wr_req && (fifo_level != LW'(FIFO_DEPTH) || pop);
    drop   = wr_req && !wr;
  end
  assign bit_out   = shreg[EXTRACT_BITS-1];
  assign bit_valid = (state == SHIFT);
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= word;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_z       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      reject_cnt <= '0;
      drop_cnt   <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      s1_valid <= n1_valid;
      if (n1_valid) begin
        s1_x <= xn1;
        s1_y <= yn1;
        s1_z <= zn1;
      end
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      fifo_level <= fifo_level + LW'(wr) - LW'(pop);
      if (rej && reject_cnt != 16'hFFFF) reject_cnt <= reject_cnt + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
      if (pop) begin
        state   <= SHIFT;
        shreg   <= mem[rptr];
        bit_cnt <= '0;
      end else if (accept) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 1'b1;
        if (last) state <= IDLE;
      end
    end
  end
endmodule
